// File: rtl/eci_cmd_defs.sv
// Shared ECI command definitions: cache-line geometry,
// allocation-record type and read-scheduler FSM states.
package eci_cmd_defs;

    localparam int ECI_ADDR_BITS   = 48;
    localparam int ECI_CL_BYTES    = 128;
    localparam int ECI_CL_BITS     = 7;
    localparam int ECI_ID_MAX_BITS = 6;

    typedef logic [ECI_ID_MAX_BITS-1:0] eci_id_t;

    typedef struct packed {
        logic    vc;
        eci_id_t id;
    } eci_ord_t;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } eci_rd_state_e;

endpackage

// File: rtl/eci_id_pool.sv
// Per-VC transaction ID pool: free bitmap, lowest-free
// allocator, release and sticky double-free detection.
module eci_id_pool #(
    parameter int N_THREADS = 32,
    parameter int ID_BITS   = $clog2(N_THREADS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_req,
    output logic               alloc_gnt,
    output logic [ID_BITS-1:0] alloc_id,
    input  logic               rel_valid,
    input  logic [ID_BITS-1:0] rel_id,
    output logic               empty,
    output logic               all_free,
    output logic               err
);

    logic [N_THREADS-1:0] free;
    logic [N_THREADS-1:0] free_n;

    assign empty     = (free == '0);
    assign all_free  = &free;
    assign alloc_gnt = alloc_req & ~empty;

    // Lowest set bit of the registered bitmap wins
    always_comb begin
        alloc_id = '0;
        for (int i = N_THREADS - 1; i >= 0; i--) begin
            if (free[i]) begin
                alloc_id = ID_BITS'(i);
            end
        end
    end

    // Allocation clears, a valid release sets; a release of a
    // free ID leaves the bitmap alone
    always_comb begin
        free_n = free;
        if (alloc_gnt) begin
            free_n[alloc_id] = 1'b0;
        end
        if (rel_valid && !free[rel_id]) begin
            free_n[rel_id] = 1'b1;
        end
    end

    // Bitmap register and sticky double-free flag
    always_ff @(posedge clk) begin
        if (rst) begin
            free <= '1;
            err  <= 1'b0;
        end else begin
            free <= free_n;
            if (rel_valid && free[rel_id]) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/eci_rd_vc_scheduler.sv
// Splits multi-line reads into 128 B lines, steers each line to
// VC0/VC1 by address bit 7 and tags it with a per-VC ID.
module eci_rd_vc_scheduler
    import eci_cmd_defs::*;
#(
    parameter int N_THREADS = 32,
    parameter int ADDR_BITS = ECI_ADDR_BITS,
    parameter int ID_BITS   = $clog2(N_THREADS)
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [ADDR_BITS-1:0]   req_addr,
    input  logic [7:0]             req_len,
    input  logic                   req_valid,
    output logic                   req_ready,
    output logic [2*ADDR_BITS-1:0] vc_addr,
    output logic [2*ID_BITS-1:0]   vc_id,
    output logic [1:0]             vc_valid,
    input  logic [1:0]             vc_ready,
    input  logic [1:0]             cpl_valid,
    input  logic [2*ID_BITS-1:0]   cpl_id,
    output logic                   ord_valid,
    output logic                   ord_vc,
    output logic [ID_BITS-1:0]     ord_id,
    output logic                   busy,
    output logic                   err_cpl
);

    eci_rd_state_e state;
    eci_rd_state_e state_n;

    logic [ADDR_BITS-1:0] cur_addr;
    logic [7:0]           remaining;

    logic                 slot_full;
    logic [ADDR_BITS-1:0] slot_addr;
    eci_ord_t             slot_ord;

    logic [1:0]         alloc_req;
    logic [1:0]         alloc_gnt;
    logic [ID_BITS-1:0] alloc_id [2];
    logic [1:0]         pool_empty;
    logic [1:0]         pool_all_free;
    logic [1:0]         pool_err;

    logic               tgt_vc;
    logic               slot_hs;
    logic               slot_open;
    logic               load;
    logic [ID_BITS-1:0] load_id;
    logic               req_hs;

    assign tgt_vc    = cur_addr[ECI_CL_BITS];
    assign slot_hs   = slot_full & vc_ready[slot_ord.vc];
    assign slot_open = ~slot_full | slot_hs;
    assign load      = |alloc_gnt;
    assign load_id   = alloc_id[tgt_vc];
    assign req_hs    = req_valid & req_ready;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_pool
            eci_id_pool #(
                .N_THREADS (N_THREADS),
                .ID_BITS   (ID_BITS)
            ) u_pool (
                .clk       (aclk),
                .rst       (areset),
                .alloc_req (alloc_req[g]),
                .alloc_gnt (alloc_gnt[g]),
                .alloc_id  (alloc_id[g]),
                .rel_valid (cpl_valid[g]),
                .rel_id    (cpl_id[g*ID_BITS +: ID_BITS]),
                .empty     (pool_empty[g]),
                .all_free  (pool_all_free[g]),
                .err       (pool_err[g])
            );
        end
    endgenerate

    // Ask only the target VC's pool, only when the slot can take a line
    always_comb begin
        alloc_req = 2'b00;
        if (state == ST_ISSUE && slot_open) begin
            alloc_req[tgt_vc] = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next state and request-side handshake
    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (load && remaining == 8'd0) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Line walker and output slot
    always_ff @(posedge aclk) begin
        if (areset) begin
            cur_addr  <= '0;
            remaining <= '0;
            slot_full <= 1'b0;
            slot_addr <= '0;
            slot_ord  <= '0;
        end else begin
            if (req_hs) begin
                cur_addr  <= req_addr & ~ADDR_BITS'(ECI_CL_BYTES - 1);
                remaining <= req_len;
            end else if (load) begin
                cur_addr  <= cur_addr + ADDR_BITS'(ECI_CL_BYTES);
                remaining <= remaining - 8'd1;
            end
            if (load) begin
                slot_full   <= 1'b1;
                slot_addr   <= cur_addr;
                slot_ord.vc <= tgt_vc;
                slot_ord.id <= eci_id_t'(load_id);
            end else if (slot_hs) begin
                slot_full <= 1'b0;
            end
        end
    end

    // Slot drives both VCs; only the owning VC sees valid
    always_comb begin
        vc_valid = 2'b00;
        if (slot_full) begin
            vc_valid[slot_ord.vc] = 1'b1;
        end
    end

    assign vc_addr   = {2{slot_addr}};
    assign vc_id     = {2{ID_BITS'(slot_ord.id)}};
    assign ord_valid = slot_hs;
    assign ord_vc    = slot_ord.vc;
    assign ord_id    = ID_BITS'(slot_ord.id);
    assign err_cpl   = |pool_err;
    assign busy      = (state != ST_IDLE) | slot_full | ~(&pool_all_free);

endmodule
